clk_enable_scheduler: RTL and testbench

Run/step/halt controller that sequences the processor's slow clocking. It issues single-cycle clock-enable ticks on SYS_clk instead of a derived clock. Ticks run free at a programmable divisor, or one per step request. A halt request from the CPU stops ticking. It sits between the board inputs (switches, debounced buttons) and the datapath's clock enable.

---
 rtl/clk_enable_scheduler.sv | 79 +++++++
 tb/tb_clk_enable_scheduler.sv | 110 +++++++++++
 2 files changed

// File: rtl/clk_enable_scheduler.sv
// clk_enable_scheduler: run/step/halt sequencer issuing one-cycle clock-enable ticks on SYS_clk
module clk_enable_scheduler #(
    parameter int CNT_W       = 28,
    parameter int DEFAULT_DIV = 125_000_000,
    parameter int CYC_W       = 32
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             resume,
    input  logic             halt_req,
    input  logic             div_wr,
    input  logic [CNT_W-1:0] div_in,
    output logic             tick,
    output logic [1:0]       state,
    output logic             busy,
    output logic [CYC_W-1:0] cycle_count
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, HALTED = 2'b11} state_t;

    state_t           st, st_n;
    logic [CNT_W-1:0] cnt, cnt_n, div_reg, div_n;
    logic             tick_n, step_prev, step_rise, term;

    assign step_rise = step_req & ~step_prev;
    assign term      = (st == RUN || st == STEP) && cnt == div_reg - 1'b1;
    assign state     = st;
    assign busy      = st == RUN || st == STEP;

    // Next state, divisor counter and tick; a dropped run request suppresses a coincident terminal tick
    always_comb begin
        st_n   = st;
        cnt_n  = '0;
        tick_n = 1'b0;
        div_n  = div_reg;
        case (st)
            IDLE: begin
                if (div_wr) div_n = div_in == '0 ? CNT_W'(1) : div_in;
                st_n = run_req ? RUN : step_rise ? STEP : IDLE;
            end
            RUN: begin
                cnt_n  = term ? '0 : cnt + 1'b1;
                tick_n = term;
                if (halt_req) st_n = HALTED;
                else if (!run_req) begin
                    st_n   = IDLE;
                    cnt_n  = '0;
                    tick_n = 1'b0;
                end
            end
            STEP: begin
                cnt_n  = term ? '0 : cnt + 1'b1;
                tick_n = term;
                st_n   = halt_req ? HALTED : term ? IDLE : STEP;
            end
            default: st_n = resume ? IDLE : HALTED;
        endcase
    end

    // State register with synchronous active-low reset; cycle_count follows the issued tick
    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset) begin
            st          <= IDLE;
            cnt         <= '0;
            div_reg     <= CNT_W'(DEFAULT_DIV);
            tick        <= 1'b0;
            cycle_count <= '0;
            step_prev   <= 1'b0;
        end else begin
            st          <= st_n;
            cnt         <= cnt_n;
            div_reg     <= div_n;
            tick        <= tick_n;
            cycle_count <= cycle_count + CYC_W'(tick_n);
            step_prev   <= step_req;
        end
    end
endmodule

// File: tb/tb_clk_enable_scheduler.sv
// tb_clk_enable_scheduler: directed vector bench for the run/step/halt tick scheduler
module tb_clk_enable_scheduler;
    localparam int CNT_W = 28;
    localparam int CYC_W = 32;

    logic             SYS_clk = 1'b0, SYS_reset = 1'b0;
    logic             run_req = 1'b0, step_req = 1'b0, resume = 1'b0, halt_req = 1'b0, div_wr = 1'b0;
    logic [CNT_W-1:0] div_in = '0;
    logic             tick, busy;
    logic [1:0]       state;
    logic [CYC_W-1:0] cycle_count;

    int compared = 0, mismatched = 0;

    clk_enable_scheduler #(.CNT_W(CNT_W), .DEFAULT_DIV(4), .CYC_W(CYC_W)) dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .run_req(run_req), .step_req(step_req),
        .resume(resume), .halt_req(halt_req), .div_wr(div_wr), .div_in(div_in),
        .tick(tick), .state(state), .busy(busy), .cycle_count(cycle_count)
    );

    always #5 SYS_clk = ~SYS_clk;

    typedef struct {
        logic             rst_n, run, step, res, halt, dwr;
        logic [CNT_W-1:0] din;
        logic             t;
        logic [1:0]       st;
        logic [CYC_W-1:0] cc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rn, r, s, rs, h, dw, input int din,
                                input logic t, input int st, input int cc);
        vec_t v;
        v.rst_n = rn; v.run = r; v.step = s; v.res = rs; v.halt = h; v.dwr = dw;
        v.din = CNT_W'(din); v.t = t; v.st = 2'(st); v.cc = CYC_W'(cc);
        return v;
    endfunction

    task automatic add(input logic rn, r, s, rs, h, dw, input int din,
                       input logic t, input int st, input int cc);
        vq.push_back(mk(rn, r, s, rs, h, dw, din, t, st, cc));
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one vector, let one rising edge pass, then compare all outputs
    task automatic apply(input vec_t v, input string name);
        SYS_reset = v.rst_n; run_req = v.run; step_req = v.step; resume = v.res;
        halt_req = v.halt; div_wr = v.dwr; div_in = v.din;
        @(posedge SYS_clk);
        #1;
        check({name, ".tick"}, 64'(tick), 64'(v.t));
        check({name, ".state"}, 64'(state), 64'(v.st));
        check({name, ".busy"}, 64'(busy), 64'(v.st == 2'b01 || v.st == 2'b10));
        check({name, ".cycle_count"}, 64'(cycle_count), 64'(v.cc));
    endtask

    initial begin
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 12; k++) add(1, 1, 0, 0, 0, 0, 0, k % 4 == 0, 1, k / 4);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 3);
        add(1, 1, 0, 0, 0, 0, 0, 0, 1, 3);
        for (int k = 1; k <= 3; k++) add(1, 1, 0, 0, 0, 0, 0, 1, 1, 3 + k);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 6);
        add(1, 0, 0, 0, 0, 1, 3, 0, 0, 6);
        add(1, 0, 1, 0, 0, 0, 0, 0, 2, 6);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2, 6);
        add(1, 1, 1, 0, 0, 0, 0, 0, 2, 6);
        add(1, 0, 1, 0, 0, 0, 0, 1, 0, 7);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0, 7);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0, 7);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 7);

        for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("vec%0d", i));

        apply(mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 7), "halt_div");
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 7), "halt_enter");
        for (int k = 1; k <= 3; k++) apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 7), $sformatf("halt_run%0d", k));
        apply(mk(1, 1, 0, 0, 1, 0, 0, 1, 3, 8), "halt_term");
        for (int k = 0; k < 20; k++)
            apply(mk(1, 1, k % 2, 0, k % 3 == 0, 1, 7, 0, 3, 8), $sformatf("halted%0d", k));
        apply(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 8), "resume");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 8), "idle_after_resume");

        apply(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 8), "rst_div");
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 8), "rst_enter");
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 8), "rst_run1");
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 8), "rst_run2");
        apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "rst_abort");
        apply(mk(1, 1, 0, 0, 0, 1, 5, 0, 1, 0), "wr_and_run");
        for (int k = 1; k <= 10; k++)
            apply(mk(1, 1, 0, 0, 0, k == 1, 9, k % 5 == 0, 1, k / 5), $sformatf("div5_run%0d", k));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2), "final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
